instr_decode_issue: RTL and testbench

INSTR_DECODE_ISSUE -- requirements
Module: instr_decode_issue

---
 rtl/instr_decode_issue.sv | 118 +++++++++++
 tb/tb_instr_decode_issue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_issue.sv
// Instruction fetch / decode / issue front end: fetches a 16-bit word, expands
// its opcode to a one-hot control word and holds it until the control FSM retires it.
module instr_decode_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [15:0]      imem_data,
    output logic [26:0]      opcode_out,
    output logic [7:0]       imm_out,
    output logic             op_valid,
    input  logic             op_done,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE
    } state_t;

    state_t           r_state;
    logic [15:0]      r_ir;
    logic             r_imemReq;
    logic             r_opValid;
    logic [26:0]      r_opcode;
    logic [7:0]       r_imm;
    logic [CNT_W-1:0] r_retired;

    logic [4:0]       w_hotIdx;
    logic [22:0]      w_oneHot;
    logic [3:0]       w_op;
    logic [1:0]       w_sub;

    assign w_op  = r_ir[15:12];
    assign w_sub = r_ir[9:8];

    // Opcodes 4..11 have no subfunction and map linearly onto bits 7..14.
    always_comb begin
        w_hotIdx = 5'd0;
        case (w_op)
            4'h0:    w_hotIdx = 5'd0;
            4'h1:    w_hotIdx = 5'd1 + {3'b000, w_sub};
            4'h2:    w_hotIdx = 5'd5;
            4'h3:    w_hotIdx = 5'd6;
            4'hC:    w_hotIdx = 5'd15 + {4'b0000, r_ir[8]};
            4'hD:    w_hotIdx = 5'd17;
            4'hE:    w_hotIdx = 5'd18;
            4'hF:    w_hotIdx = 5'd19 + {3'b000, w_sub};
            default: w_hotIdx = {1'b0, w_op} + 5'd3;
        endcase
    end

    assign w_oneHot = 23'd1 << w_hotIdx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            r_imemReq <= 1'b0;
            r_opValid <= 1'b0;
            r_opcode  <= 27'h0000001;
            r_imm     <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_state   <= FETCH;
                        r_imemReq <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_ir      <= imem_data;
                        r_imemReq <= 1'b0;
                        r_state   <= DECODE;
                    end
                end
                DECODE: begin
                    r_opcode  <= {r_ir[11:10], r_ir[9:8], w_oneHot};
                    r_imm     <= r_ir[7:0];
                    r_opValid <= 1'b1;
                    r_state   <= ISSUE;
                end
                ISSUE: begin
                    // run is sampled only at retirement, so a fetch never starts mid-issue.
                    if (op_done) begin
                        r_retired <= r_retired + 1'b1;
                        r_opValid <= 1'b0;
                        if (run) begin
                            r_state   <= FETCH;
                            r_imemReq <= 1'b1;
                        end else begin
                            r_state   <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_imemReq <= 1'b0;
                    r_opValid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = r_imemReq;
    assign op_valid   = r_opValid;
    assign opcode_out = r_opcode;
    assign imm_out    = r_imm;
    assign retired    = r_retired;

endmodule

// File: tb/tb_instr_decode_issue.sv
// Randomized bench for instr_decode_issue, compared against an opcode-table
// reference model; a narrow retire counter makes the wrap reachable.
module tb_instr_decode_issue;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             run;
    logic             imem_req;
    logic             imem_ack;
    logic [15:0]      imem_data;
    logic [26:0]      opcode_out;
    logic [7:0]       imm_out;
    logic             op_valid;
    logic             op_done;
    logic [CNT_W-1:0] retired;

    int testsRun    = 0;
    int testsFailed = 0;
    int modelRetired = 0;

    // Base one-hot position of each opcode before any subfunction offset.
    int baseIdx [16] = '{0, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19};

    always #5 clock = ~clock;

    instr_decode_issue #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .opcode_out (opcode_out),
        .imm_out    (imm_out),
        .op_valid   (op_valid),
        .op_done    (op_done),
        .retired    (retired)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [26:0] refOpcode(input logic [15:0] ins);
        int op;
        int sub;
        int idx;
        logic [22:0] hot;
        op  = int'(ins[15:12]);
        sub = int'(ins[9:8]);
        idx = baseIdx[op];
        if (op == 1 || op == 15) idx += sub;
        else if (op == 12) idx += sub % 2;
        hot = '0;
        hot[idx] = 1'b1;
        return {ins[11:10], ins[9:8], hot};
    endfunction

    task automatic waitReq();
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (imem_req !== 1'b1) checkOutput("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    // One full instruction: fetch with latency, decode, hold in issue, retire.
    task automatic applyStimulus(input logic [15:0] ins, input int lat, input int hold, input bit dropRun);
        logic [26:0] expOp;
        expOp = refOpcode(ins);
        waitReq();
        if (dropRun) run = 1'b0;
        repeat (lat) begin
            op_done = 1'($urandom_range(0, 1));
            @(negedge clock);
            checkOutput("req_fetch", {31'd0, imem_req}, 32'd1);
        end
        op_done   = 1'b0;
        imem_ack  = 1'b1;
        imem_data = ins;
        @(negedge clock);
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        op_done   = 1'($urandom_range(0, 1));
        checkOutput("valid_decode", {31'd0, op_valid}, 32'd0);
        checkOutput("req_decode", {31'd0, imem_req}, 32'd0);
        @(negedge clock);
        op_done = 1'b0;
        checkOutput("valid_issue", {31'd0, op_valid}, 32'd1);
        checkOutput("opcode", {5'd0, opcode_out}, {5'd0, expOp});
        checkOutput("imm", {24'd0, imm_out}, {24'd0, ins[7:0]});
        checkOutput("retired_hold", {28'd0, retired}, 32'(modelRetired));
        repeat (hold) begin
            imem_ack = 1'($urandom_range(0, 1));
            @(negedge clock);
            checkOutput("valid_stable", {31'd0, op_valid}, 32'd1);
            checkOutput("opcode_stable", {5'd0, opcode_out}, {5'd0, expOp});
            checkOutput("req_issue", {31'd0, imem_req}, 32'd0);
        end
        imem_ack = 1'b0;
        op_done  = 1'b1;
        @(negedge clock);
        op_done = 1'b0;
        modelRetired = (modelRetired + 1) % (1 << CNT_W);
        checkOutput("retired", {28'd0, retired}, 32'(modelRetired));
        checkOutput("valid_after_done", {31'd0, op_valid}, 32'd0);
        checkOutput("req_after_done", {31'd0, imem_req}, {31'd0, run});
    endtask

    initial begin
        reset     = 1'b0;
        run       = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0;
        op_done   = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_valid", {31'd0, op_valid}, 32'd0);
        checkOutput("rst_opcode", {5'd0, opcode_out}, 32'h0000001);
        checkOutput("rst_imm", {24'd0, imm_out}, 32'd0);
        checkOutput("rst_retired", {28'd0, retired}, 32'd0);

        run   = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("req_after_reset", {31'd0, imem_req}, 32'd1);

        applyStimulus(16'h4E00, 2, 0, 1'b0);
        checkOutput("add_directed", {5'd0, refOpcode(16'h4E00)}, 32'h7000080);
        applyStimulus(16'hF305, 1, 3, 1'b0);
        applyStimulus(16'h9A3C, 0, 20, 1'b0);
        applyStimulus(16'h2544, 2, 1, 1'b1);
        repeat (3) begin
            @(negedge clock);
            checkOutput("idle_req", {31'd0, imem_req}, 32'd0);
            checkOutput("idle_valid", {31'd0, op_valid}, 32'd0);
        end
        run = 1'b1;

        for (int op = 0; op < 16; op++) begin
            for (int sub = 0; sub < 4; sub++) begin
                logic [15:0] ins;
                ins = {4'(op), 2'($urandom_range(0, 3)), 2'(sub), 8'($urandom)};
                applyStimulus(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
            end
        end

        // Reset asserted in the middle of an issue cycle.
        waitReq();
        imem_ack  = 1'b1;
        imem_data = 16'h7123;
        @(negedge clock);
        imem_ack = 1'b0;
        @(negedge clock);
        checkOutput("pre_reset_valid", {31'd0, op_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_valid", {31'd0, op_valid}, 32'd0);
        checkOutput("async_opcode", {5'd0, opcode_out}, 32'h0000001);
        checkOutput("async_retired", {28'd0, retired}, 32'd0);
        checkOutput("async_req", {31'd0, imem_req}, 32'd0);
        modelRetired = 0;
        op_done = 1'b1;
        @(negedge clock);
        op_done = 1'b0;
        checkOutput("rst_done_ignored", {28'd0, retired}, 32'd0);

        // Reset asserted mid-fetch; a late ack must not revive the fetch.
        run   = 1'b1;
        reset = 1'b1;
        waitReq();
        #2 reset = 1'b0;
        #1;
        checkOutput("fetch_rst_req", {31'd0, imem_req}, 32'd0);
        run = 1'b0;
        @(negedge clock);
        reset     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 16'h4E00;
        @(negedge clock);
        imem_ack = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checkOutput("late_ack_valid", {31'd0, op_valid}, 32'd0);
            checkOutput("late_ack_req", {31'd0, imem_req}, 32'd0);
        end
        checkOutput("late_ack_opcode", {5'd0, opcode_out}, 32'h0000001);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
